// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer and its return-address stack.
package pc_seq_pkg;

  localparam int PC_STEP = 2;

  typedef enum logic {
    SEQ_RUN,
    SEQ_HALT
  } seq_state_e;

  // Which request won the priority mux this cycle; NONE covers hold and advance.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BRANCH,
    SRC_CALL,
    SRC_RET
  } redir_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty leaves state untouched. Overflow/underflow are single-cycle pulses.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_data_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               top_q, top_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        full, empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Push wins over pop; the sequencer never asks for both at once.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (push_i) begin
      top_d = top_q + PW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (pop_i && !empty) begin
      top_d   = top_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q   <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      if (push_i) mem_q[top_d] <= push_data_i;
    end
  end

  assign top_data_o  = mem_q[top_q];
  assign count_o     = count_q;
  assign overflow_o  = push_i && full;
  assign underflow_o = pop_i && !push_i && empty;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks hold / advance / redirect each cycle and drives the
// PC register's jump pair combinationally; owns run/halt FSM, RAS and sticky errors.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  localparam int              CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic [WIDTH-1:0] branch_addr_i,
  input  logic             call_en_i,
  input  logic [WIDTH-1:0] call_addr_i,
  input  logic             ret_en_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             pc_jump_en_o,
  output logic [WIDTH-1:0] pc_jump_addr_o,
  output logic             halted_o,
  output logic [CW-1:0]    ras_count_o,
  output logic             ras_overflow_o,
  output logic             ras_underflow_o,
  output logic             seq_err_o
);

  seq_state_e       state_q, state_d;
  redir_src_e       src;
  logic [WIDTH-1:0] target;
  logic             accepted, conflict, misalign;
  logic             ras_push, ras_pop, ras_ovf, ras_udf;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;
  logic             ovf_q, udf_q, err_q;

  assign accepted = !reset_i && (state_q == SEQ_RUN) && !halt_i && !stall_i;
  assign conflict = accepted && ($countones({ret_en_i, call_en_i, branch_en_i}) > 1);

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= SEQ_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_HALT: if (resume_i) state_d = SEQ_RUN;
      default: begin
        if (halt_i) state_d = SEQ_HALT;
        else if (!stall_i && ret_en_i && ras_count == '0) state_d = SEQ_HALT;
      end
    endcase
  end

  always_comb begin
    src      = SRC_NONE;
    target   = pc_i;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (accepted) begin
      if (ret_en_i) begin
        src     = SRC_RET;
        ras_pop = 1'b1;
        target  = (ras_count != '0) ? ras_top : RESET_PC;
      end else if (call_en_i) begin
        src      = SRC_CALL;
        ras_push = 1'b1;
        target   = call_addr_i;
      end else if (branch_en_i) begin
        src    = SRC_BRANCH;
        target = branch_addr_i;
      end
    end
  end

  assign misalign = (src != SRC_NONE) && target[0];

  // Advance only when RUN accepted no redirect; every other case drives the pair.
  always_comb begin
    pc_jump_en_o   = 1'b1;
    pc_jump_addr_o = pc_i;
    if (reset_i) begin
      pc_jump_addr_o = RESET_PC;
    end else if (src != SRC_NONE) begin
      pc_jump_addr_o = {target[WIDTH-1:1], 1'b0};
    end else if (accepted) begin
      pc_jump_en_o = 1'b0;
    end
  end

  pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (WIDTH'(pc_i + WIDTH'(PC_STEP))),
    .top_data_o  (ras_top),
    .count_o     (ras_count),
    .overflow_o  (ras_ovf),
    .underflow_o (ras_udf)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ras_ovf;
      udf_q <= udf_q | ras_udf;
      err_q <= err_q | conflict | misalign;
    end
  end

  assign halted_o        = (state_q == SEQ_HALT);
  assign ras_count_o     = ras_count;
  assign ras_overflow_o  = ovf_q;
  assign ras_underflow_o = udf_q;
  assign seq_err_o       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the bench also plays the PC register so
// advance/jump behaviour can be followed across cycles.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        stall, branch_en, call_en, ret_en, halt, resume;
  logic [15:0] branch_addr, call_addr;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        halted, ovf, udf, err;
  logic [2:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .pc_i            (pc),
    .stall_i         (stall),
    .branch_en_i     (branch_en),
    .branch_addr_i   (branch_addr),
    .call_en_i       (call_en),
    .call_addr_i     (call_addr),
    .ret_en_i        (ret_en),
    .halt_i          (halt),
    .resume_i        (resume),
    .pc_jump_en_o    (jump_en),
    .pc_jump_addr_o  (jump_addr),
    .halted_o        (halted),
    .ras_count_o     (cnt),
    .ras_overflow_o  (ovf),
    .ras_underflow_o (udf),
    .seq_err_o       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: the PC register takes the jump pair presented before the edge.
  task automatic cyc();
    logic [15:0] nxt;
    #1;
    nxt = jump_en ? jump_addr : 16'(pc + 16'd2);
    @(posedge clk);
    #1;
    pc = nxt;
  endtask

  task automatic redir(input string tag, input logic [15:0] addr);
    #1;
    chk({tag, "_en"}, 32'(jump_en), 32'd1);
    chk({tag, "_addr"}, 32'(jump_addr), 32'(addr));
  endtask

  task automatic clr();
    stall = 0; branch_en = 0; call_en = 0; ret_en = 0; halt = 0; resume = 0;
  endtask

  initial begin
    clr();
    branch_addr = 0; call_addr = 0;
    rst = 1; pc = 16'h1234;
    @(negedge clk);
    redir("rst_hold", 16'h0000);
    cyc(); cyc();
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_flags", {29'd0, ovf, udf, err}, 0);
    rst = 0;
    #1 chk("adv0_en", 32'(jump_en), 0);
    chk("adv0_pc", 32'(pc), 32'h0);
    cyc(); chk("adv_pc2", 32'(pc), 32'h2);
    cyc(); chk("adv_pc4", 32'(pc), 32'h4);
    cyc(); chk("adv_pc6", 32'(pc), 32'h6);

    // nested call/return
    pc = 16'h0010; call_en = 1; call_addr = 16'h0100;
    redir("call1", 16'h0100);
    cyc(); chk("call1_cnt", 32'(cnt), 1); chk("call1_pc", 32'(pc), 32'h0100);
    pc = 16'h0104; call_addr = 16'h0200;
    redir("call2", 16'h0200);
    cyc(); chk("call2_cnt", 32'(cnt), 2);
    call_en = 0; ret_en = 1;
    redir("ret1", 16'h0106);
    cyc(); chk("ret1_cnt", 32'(cnt), 1);
    redir("ret2", 16'h0012);
    cyc(); chk("ret2_cnt", 32'(cnt), 0);
    ret_en = 0;
    chk("nest_flags", {29'd0, ovf, udf, err}, 0);

    // overflow then underflow
    call_addr = 16'h2000; call_en = 1;
    for (int i = 0; i < 5; i++) begin
      pc = 16'h1000 + 16'(i * 16);
      cyc();
    end
    call_en = 0;
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_cnt", 32'(cnt), 4);
    ret_en = 1;
    for (int i = 4; i >= 1; i--) begin
      redir($sformatf("ovf_ret%0d", i), 16'h1002 + 16'(i * 16));
      cyc();
    end
    chk("ovf_cnt0", 32'(cnt), 0);
    chk("udf_pre", 32'(udf), 0);
    redir("udf_jump", 16'h0000);
    cyc(); ret_en = 0;
    chk("udf_flag", 32'(udf), 1);
    chk("udf_halted", 32'(halted), 1);
    chk("udf_noerr", 32'(err), 0);
    rst = 1; cyc(); rst = 0;
    chk("rst2_flags", {29'd0, ovf, udf, err}, 0);
    chk("rst2_halted", 32'(halted), 0);

    // stall and priority
    pc = 16'h0020; stall = 1; branch_en = 1; branch_addr = 16'h0400;
    redir("stall_hold", 16'h0020);
    cyc(); chk("stall_pc", 32'(pc), 32'h0020);
    stall = 0;
    redir("stall_rel", 16'h0400);
    cyc(); chk("stall_noerr", 32'(err), 0);
    pc = 16'h0040; call_en = 1; call_addr = 16'h0300; branch_addr = 16'h0500;
    redir("prio_call", 16'h0300);
    cyc(); clr();
    chk("prio_err", 32'(err), 1);
    chk("prio_cnt", 32'(cnt), 1);

    // halt / resume; seq_err stays set until reset
    pc = 16'h0030; halt = 1;
    redir("halt_hold", 16'h0030);
    cyc(); halt = 0;
    chk("halt_st", 32'(halted), 1);
    branch_en = 1; branch_addr = 16'h0400;
    redir("halt_ign", 16'h0030);
    cyc(); branch_en = 0; resume = 1;
    redir("resume_hold", 16'h0030);
    cyc(); resume = 0;
    chk("resume_st", 32'(halted), 0);
    #1 chk("resume_adv", 32'(jump_en), 0);
    cyc(); chk("resume_pc", 32'(pc), 32'h0032);
    halt = 1; cyc(); halt = 0;
    chk("halt2_st", 32'(halted), 1);
    chk("err_sticky", 32'(err), 1);
    rst = 1; cyc(); rst = 0;
    chk("rst3_halted", 32'(halted), 0);
    chk("rst3_flags", {29'd0, ovf, udf, err}, 0);
    chk("rst3_cnt", 32'(cnt), 0);

    // misaligned target and pc wrap
    pc = 16'h0050; branch_en = 1; branch_addr = 16'h0101;
    redir("mis_br", 16'h0100);
    cyc(); branch_en = 0;
    chk("mis_err", 32'(err), 1);
    pc = 16'hFFFE; call_en = 1; call_addr = 16'h0600;
    redir("wrap_call", 16'h0600);
    cyc(); call_en = 0;
    chk("wrap_cnt", 32'(cnt), 1);
    ret_en = 1;
    redir("wrap_ret", 16'h0000);
    cyc(); ret_en = 0;
    chk("wrap_cnt0", 32'(cnt), 0);
    chk("wrap_noudf", 32'(udf), 0);
    chk("wrap_run", 32'(halted), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 16-bit program counter register.
- Every cycle it decides whether the PC advances by 2 (default), holds, or loads a redirect target, by driving the PC's jump_en/jump_addr pair.
- Owns a small return-address stack (RAS) for call/return, a run/halt state machine, and sticky error flags.
- Sits between decode/execute control and the PC register.

Parameters:
- WIDTH, 16, address width; PC step is fixed at 2.
- RAS_DEPTH, 4, number of return-address entries; must be a power of 2, ≥2.
- RESET_PC, 16'h0000, address forced during reset and after a fatal RAS underflow.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc  in  WIDTH  current PC register value
- stall  in  1  pipeline stall: hold PC
- branch_en  in  1  taken branch this cycle
- branch_addr  in  WIDTH  branch target
- call_en  in  1  call: push pc+2, jump to call_addr
- call_addr  in  WIDTH  call target
- ret_en  in  1  return: pop RAS, jump to popped address
- halt  in  1  request halt
- resume  in  1  leave HALT state
- pc_jump_en  out  1  to PC register jump enable
- pc_jump_addr  out  WIDTH  to PC register jump address
- halted  out  1  1 while in HALT state
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  out  1  sticky: push onto full RAS
- ras_underflow  out  1  sticky: pop from empty RAS
- seq_err  out  1  sticky: conflicting requests or misaligned target

Behaviour:
- **Timing.** pc_jump_en/pc_jump_addr are combinational from current inputs and state (zero latency), so the PC register acts on the same clock edge. State, RAS and flags are registered.
- **Hold.** Defined as pc_jump_en=1, pc_jump_addr=pc.
- **Advance.** Defined as pc_jump_en=0, letting the PC self-increment by 2.
- **Reset.**
  - While reset=1: pc_jump_en=1, pc_jump_addr=RESET_PC.
  - Next state is RUN; RAS empty (ras_count=0).
  - halted=0; all sticky flags cleared.
  - Reset mid-call or mid-halt discards all state.
- **States.** RUN and HALT.
  - HALT:
    - Always hold.
    - resume=1 → next state RUN; the PC still holds in that cycle and advances from the following cycle.
    - All redirect inputs are ignored.
  - RUN, priority from highest to lowest:
    1. halt: hold; next state HALT.
    2. stall: hold. Redirects are ignored; the requester keeps them asserted until stall drops.
    3. ret_en:
       - If ras_count>0: pop; jump to the top entry.
       - If ras_count=0: set ras_underflow, jump to RESET_PC, next state HALT.
    4. call_en: push (pc+2) mod 2^WIDTH; jump to call_addr.
    5. branch_en: jump to branch_addr.
    6. None of the above: advance.
- **Conflicts.** More than one of ret_en, call_en, branch_en high in an accepted RUN cycle sets seq_err. The highest priority request still executes.
- **RAS.**
  - Circular buffer with top pointer and count.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, set ras_overflow.
  - Push/pop pointer arithmetic wraps modulo RAS_DEPTH.
- **Alignment.** Any target with bit0=1 (branch, call or popped) is emitted with bit0 cleared and sets seq_err.
- **Wrap-around.** pc+2 wraps at 2^WIDTH; return address 0 is legal.
- **Sticky flags.** Cleared only by reset.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enum (SEQ_RUN, SEQ_HALT)
  - PC_STEP=2
  - redirect-source enum (NONE, BRANCH, CALL, RET) for debug/trace
- One natural sub-module: pc_ras (parameterized LIFO with push, pop, count, overflow/underflow pulses), instantiated once.
- The sequencer owns the FSM, priority mux and sticky flags.

Test Plan:
- **Reset and advance.** Assert reset 2 cycles with pc=16'h1234 → pc_jump_en=1, addr=0. Release with no requests → pc_jump_en=0 and PC counts 0,2,4,6.
- **Call/return nesting.** Call at pc=0x0010 to 0x0100, then at pc=0x0104 to 0x0200, then ret, ret:
  - First two cycles jump to 0x0100 and 0x0200, ras_count 1→2.
  - Returns go to 0x0106 then 0x0012, ras_count back to 0.
  - No flags set.
- **RAS overflow and underflow.**
  - Five calls with RAS_DEPTH=4 → ras_overflow=1, ras_count=4; four rets return the newest four addresses.
  - A fifth ret → ras_underflow=1, jump to 0, halted=1 next cycle.
- **Stall and priority.**
  - stall+branch_en (target 0x0400) at pc=0x0020 → hold 0x0020.
  - Drop stall → jump to 0x0400.
  - call_en+branch_en together → call executes, seq_err=1.
- **Halt/resume.**
  - halt at pc=0x0030 → hold; halted=1 next cycle; branch_en is ignored while halted.
  - resume → one more hold cycle, then advance 0x0032.
  - Reset asserted while halted → halted=0, flags cleared.
- **Misaligned and wrap.**
  - branch to 0x0101 → addr 0x0100, seq_err=1.
  - Call at pc=0xFFFE → pushes 0x0000; the matching ret jumps to 0x0000.
